serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 106 ++++++++++
 tb/tb_serial_addsub.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder used as the serial arithmetic core.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/subtract, LSB first, one bit per clock.
// Subtraction is present only when SERIAL_ADDSUB_SUB_EN is defined; otherwise sub is ignored.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  state_t state, state_next;

  logic [N-1:0]     a_reg, b_reg;
  logic [CNT_W-1:0] cnt;
  logic             carry, sub_r, sub_in;
  logic             cout_r, ovf_r;
  logic             fa_s, fa_cout, last;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign sub_in = sub;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign sub_in     = 1'b0;
`endif

  assign last = (cnt == CNT_W'(N - 1));

  // B is inverted on the fly so the B shift register always holds the raw operand.
  serial_fa_cell u_fa (
    .x    (a_reg[0]),
    .y    (b_reg[0] ^ sub_r),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter at the top of A, so after N shifts A holds the full sum.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= sub_in;
            sub_r <= sub_in;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_reg <= {fa_s, a_reg[N-1:1]};
          b_reg <= {1'b0, b_reg[N-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout_r <= fa_cout;
            ovf_r  <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = a_reg;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (N=8); sub-vector expectations follow SERIAL_ADDSUB_SUB_EN.
module tb_serial_addsub;

  localparam int N = 8;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic       sub   = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic [7:0] sum;
  logic       cout, ovf, busy, done;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t expQ[$];
  int   total = 0, bad = 0;
  int   doneCount = 0, cyc = 0, doneCyc = 0, startCyc = 0, prevDone = 0;

  serial_addsub #(.N(N)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      doneCount++;
      doneCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", 32'(sum), 32'(e.sum));
        checkOutput("cout", 32'(cout), 32'(e.cout));
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("busy at done", 32'(busy), 32'd0);
      end
    end
  end

  // Operands are scrambled right after the start edge; the result must not care.
  task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                               input exp_t e, input bit push);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    prevDone = doneCount;
    if (push) expQ.push_back(e);
    @(posedge clk);
    #1;
    startCyc = cyc;
    start = 1'b0;
    sub   = ~s;
    a     = ~av;
    b     = bv ^ 8'h5A;
  endtask

  task automatic waitDone(input string name);
    int i;
    for (i = 0; i < 40 && doneCount == prevDone; i++) @(posedge clk);
    checkOutput({name, " done seen"}, 32'(doneCount - prevDone), 32'd1);
    checkOutput({name, " latency"}, 32'(doneCyc - startCyc), 32'(N));
  endtask

  task automatic runOp(input string name, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    applyStimulus(s, av, bv, e, 1'b1);
    waitDone(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    exp_t dummy;
    dummy = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);

    @(posedge clk);
    #2 clr_n = 1'b1;

    runOp("add 5A+33", 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
    runOp("add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    runOp("add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_SUB_EN
    runOp("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    runOp("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    runOp("sub 05-05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
`else
    runOp("sub ignored 10,20", 1'b1, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    runOp("sub ignored 80,01", 1'b1, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0);
    runOp("sub ignored 05,05", 1'b1, 8'h05, 8'h05, 8'h0A, 1'b0, 1'b0);
`endif

    // A second start in the middle of SHIFT must be dropped, not queued.
    dummy.sum = 8'h46;
    applyStimulus(1'b0, 8'h12, 8'h34, dummy, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy mid shift", 32'(busy), 32'd1);
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("ignored start");
    repeat (12) @(posedge clk);
    checkOutput("single done pulse", 32'(doneCount - prevDone), 32'd1);

    runOp("add FF+FF", 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold sum", 32'(sum), 32'hFE);
    checkOutput("hold cout", 32'(cout), 32'd1);

    // Abort an operation mid-shift; outputs must clear without waiting for a clock.
    applyStimulus(1'b0, 8'h01, 8'h01, dummy, 1'b0);
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("abort sum", 32'(sum), 32'd0);
    checkOutput("abort cout", 32'(cout), 32'd0);
    checkOutput("abort ovf", 32'(ovf), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b1;
    repeat (12) @(posedge clk);
    checkOutput("no done after abort", 32'(doneCount - prevDone), 32'd0);

    runOp("add 01+02", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
